commutation_sequencer: RTL
==========================

COMMUTATION_SEQUENCER -- requirements
Module: commutation_sequencer

Interface
REQ-001 Parameter DEAD_CYCLES, default 2: all-off gate cycles inserted before every new drive pattern; legal 0..15.
REQ-002 Parameter RESET_PERIOD, default 8'd255: step period loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 run_i  input  1  level; 1 = commutate, 0 = stop (all gates off).
REQ-006 dir_i  input  1  0 = forward (step +1), 1 = reverse (step -1); sampled at step boundaries only.
REQ-007 brake_i  input  1  level; 1 = all low-side gates on; priority over run_i.
REQ-008 cfg_valid_i  input  1  new period offered on period_i.
REQ-009 period_i  input  8  RUN cycles per step; 0 treated as 1.
REQ-010 cfg_ready_o  output  1  1 = no config pending; transfer on cfg_valid_i & cfg_ready_o.
REQ-011 gate_o  output  8  registered gate drives: [7]/[6] phase A high/low, [5]/[4] B high/low, [3]/[2] C high/low, [1:0] always 0.
REQ-012 step_o  output  3  current step index 0..5, registered.
REQ-013 step_strobe_o  output  1  one-cycle pulse in the cycle step_o takes a new value.
REQ-014 state_o  output  2  current state encoding, for debug.

Function
REQ-015 States IDLE, DEAD, RUN, BRAKE; DEAD records its exit target (RUN, BRAKE or IDLE).
REQ-016 Step patterns: 0=0x90, 1=0x18, 2=0x48, 3=0x60, 4=0x24, 5=0x84; brake pattern 0x54.
REQ-017 gate_o SHALL be 0x00 in IDLE and DEAD, the step_o pattern in RUN, 0x54 in BRAKE.
REQ-018 IDLE: run_i=1 & brake_i=0 -> DEAD(target RUN); step_o unchanged.
REQ-019 DEAD holds exactly DEAD_CYCLES cycles, then enters target; DEAD_CYCLES=0 enters target in the next cycle with DEAD skipped.
REQ-020 RUN: tick counter counts 0..max(period_q,1)-1; at terminal count step advances, step_strobe_o pulses, state -> DEAD(target RUN).
REQ-021 Step arithmetic modulo 6: forward 5->0, reverse 0->5; dir_i sampled in the terminal-count cycle.
REQ-022 Full step interval = DEAD_CYCLES + max(period_q,1) cycles.
REQ-023 Accepted config is held pending (cfg_ready_o=0) and copied to period_q at the next step advance, or in the next cycle if in IDLE; cfg_ready_o returns to 1 the cycle after the copy.
REQ-024 cfg_valid_i while cfg_ready_o=0 is ignored; offering master must hold.
REQ-025 run_i=0 in RUN -> DEAD(target IDLE); tick counter cleared; step_o retained.
REQ-026 brake_i=1 in IDLE or RUN -> DEAD(target BRAKE); brake_i=0 in BRAKE -> DEAD(target RUN if run_i else IDLE).
REQ-027 brake_i or run_i changes during DEAD retarget DEAD without restarting its count.
REQ-028 No cycle SHALL drive both high and low gate of one phase; any transition between two distinct non-zero gate_o values SHALL pass through DEAD.

Reset
REQ-029 rst_n low: state IDLE, gate_o 0x00, step_o 0, step_strobe_o 0, tick and dead counters 0, period_q RESET_PERIOD, pending cleared, cfg_ready_o 1.
REQ-030 Reset mid-step SHALL force gate_o 0x00 asynchronously; first post-reset run goes through DEAD.

Structure
REQ-031 Shared package holds state enum, step pattern table, BRAKE_PATTERN, STEP_COUNT=6.
REQ-032 One sub-module commutation_pattern_lut: combinational step index -> 8-bit pattern.

Verification
REQ-033 period 3, DEAD 2, dir 0, run_i=1 -> gate_o 00,00,90,90,90,00,00,18,18,18,...; strobe at each 00 onset after RUN.
REQ-034 dir 1 from step 0 -> step_o 5,4,3; gate_o 84,24,60 separated by 2 zero cycles.
REQ-035 period_i=0 -> one RUN cycle per step; cfg of 5 mid-step -> cfg_ready_o low until next advance, then 5-cycle steps.
REQ-036 brake_i=1 in RUN step 2 -> 00,00 then 54 held; release with run_i=1 -> 00,00 then 48.
REQ-037 rst_n low mid-RUN -> gate_o 00 same cycle, step_o 0; DEAD_CYCLES=0 build: 90 directly followed by 18, never a shared-phase overlap.

Source files
------------

// File: rtl/commutation_sequencer_pkg.sv
// Shared types and constants for the six-step commutation sequencer.
package commutation_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    localparam int STEP_COUNT = 6;

    // Gate byte layout: [7]/[6] A high/low, [5]/[4] B high/low, [3]/[2] C high/low.
    localparam logic [7:0] STEP_PAT_0 = 8'h90;
    localparam logic [7:0] STEP_PAT_1 = 8'h18;
    localparam logic [7:0] STEP_PAT_2 = 8'h48;
    localparam logic [7:0] STEP_PAT_3 = 8'h60;
    localparam logic [7:0] STEP_PAT_4 = 8'h24;
    localparam logic [7:0] STEP_PAT_5 = 8'h84;

    // All three low-side switches on.
    localparam logic [7:0] BRAKE_PATTERN = 8'h54;

    // Next step index, wrapping modulo STEP_COUNT in either direction.
    function automatic logic [2:0] step_next(input logic [2:0] step, input logic rev);
        if (rev) begin
            return (step == 3'd0) ? 3'(STEP_COUNT - 1) : step - 3'd1;
        end
        return (step == 3'(STEP_COUNT - 1)) ? 3'd0 : step + 3'd1;
    endfunction

endpackage

// File: rtl/commutation_sequencer_lut.sv
// Step index to gate drive pattern; out-of-range indices drive all gates off.
module commutation_pattern_lut
    import commutation_sequencer_pkg::*;
(
    input  logic [2:0] step,
    output logic [7:0] pattern
);

    // Pure table lookup.
    always_comb begin
        pattern = 8'h00;
        case (step)
            3'd0:    pattern = STEP_PAT_0;
            3'd1:    pattern = STEP_PAT_1;
            3'd2:    pattern = STEP_PAT_2;
            3'd3:    pattern = STEP_PAT_3;
            3'd4:    pattern = STEP_PAT_4;
            3'd5:    pattern = STEP_PAT_5;
            default: pattern = 8'h00;
        endcase
    end

endmodule

// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation sequencer with dead-time insertion, brake and
// a single-entry period configuration register.
module commutation_sequencer
    import commutation_sequencer_pkg::*;
#(
    parameter int         DEAD_CYCLES  = 2,
    parameter logic [7:0] RESET_PERIOD = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       dir_i,
    input  logic       brake_i,
    input  logic       cfg_valid_i,
    input  logic [7:0] period_i,
    output logic       cfg_ready_o,
    output logic [7:0] gate_o,
    output logic [2:0] step_o,
    output logic       step_strobe_o,
    output logic [1:0] state_o
);

    // Last value of the dead counter before leaving DEAD (unused when DEAD is skipped).
    localparam logic [3:0] DEAD_LAST = (DEAD_CYCLES == 0) ? 4'd0 : 4'(DEAD_CYCLES - 1);

    state_t     state_q, state_d;
    state_t     dead_tgt_q, dead_tgt_d;
    state_t     live_tgt;
    state_t     go_tgt;
    logic       go_dead;
    logic [3:0] dead_cnt_q, dead_cnt_d;
    logic [7:0] tick_q, tick_d;
    logic [7:0] tick_last;
    logic [2:0] step_q, step_d;
    logic       strobe_q, strobe_d;
    logic [7:0] gate_q, gate_d;
    logic [7:0] lut_pattern;
    logic [7:0] period_q;
    logic [7:0] pend_val_q;
    logic       pend_q;
    logic       advance;
    logic       accept;

    // A period of zero behaves as a one-cycle step.
    assign tick_last = ((period_q == 8'd0) ? 8'd1 : period_q) - 8'd1;

    // Where the inputs currently ask the drive to go; DEAD follows this live.
    assign live_tgt = brake_i ? ST_BRAKE : (run_i ? ST_RUN : ST_IDLE);

    assign cfg_ready_o = ~pend_q;
    assign accept      = cfg_valid_i & ~pend_q;

    commutation_pattern_lut u_lut (
        .step    (step_d),
        .pattern (lut_pattern)
    );

    // Next-state, step and counter logic.
    always_comb begin
        state_d    = state_q;
        dead_tgt_d = dead_tgt_q;
        dead_cnt_d = dead_cnt_q;
        tick_d     = tick_q;
        step_d     = step_q;
        strobe_d   = 1'b0;
        advance    = 1'b0;
        go_dead    = 1'b0;
        go_tgt     = ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (brake_i || run_i) begin
                    go_dead = 1'b1;
                    go_tgt  = live_tgt;
                end
            end
            ST_DEAD: begin
                dead_tgt_d = live_tgt;
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d    = live_tgt;
                    dead_cnt_d = 4'd0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (brake_i || !run_i) begin
                    go_dead = 1'b1;
                    go_tgt  = live_tgt;
                    tick_d  = 8'd0;
                end else if (tick_q == tick_last) begin
                    advance  = 1'b1;
                    step_d   = step_next(step_q, dir_i);
                    strobe_d = 1'b1;
                    tick_d   = 8'd0;
                    go_dead  = 1'b1;
                    go_tgt   = ST_RUN;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            ST_BRAKE: begin
                if (!brake_i) begin
                    go_dead = 1'b1;
                    go_tgt  = live_tgt;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every new drive pattern is preceded by the all-off window unless it is zero length.
        if (go_dead) begin
            if (DEAD_CYCLES == 0) begin
                state_d = go_tgt;
            end else begin
                state_d    = ST_DEAD;
                dead_tgt_d = go_tgt;
                dead_cnt_d = 4'd0;
            end
        end
    end

    // Gate drive for the state being entered, so the registered output matches state_o.
    always_comb begin
        gate_d = 8'h00;
        case (state_d)
            ST_RUN:   gate_d = lut_pattern;
            ST_BRAKE: gate_d = BRAKE_PATTERN;
            default:  gate_d = 8'h00;
        endcase
    end

    // State, counters and registered outputs; reset turns all gates off immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dead_tgt_q <= ST_IDLE;
            dead_cnt_q <= 4'd0;
            tick_q     <= 8'd0;
            step_q     <= 3'd0;
            strobe_q   <= 1'b0;
            gate_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            dead_tgt_q <= dead_tgt_d;
            dead_cnt_q <= dead_cnt_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
            strobe_q   <= strobe_d;
            gate_q     <= gate_d;
        end
    end

    // Period config: hold one pending value, apply it at a step boundary or straight away when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q   <= RESET_PERIOD;
            pend_val_q <= 8'd0;
            pend_q     <= 1'b0;
        end else if (pend_q && (advance || state_q == ST_IDLE)) begin
            period_q <= pend_val_q;
            pend_q   <= 1'b0;
        end else if (accept) begin
            pend_val_q <= period_i;
            pend_q     <= 1'b1;
        end
    end

    assign gate_o        = gate_q;
    assign step_o        = step_q;
    assign step_strobe_o = strobe_q;
    assign state_o       = state_q;

endmodule
